paddle_engine: RTL and testbench
================================

# paddle_engine

Parametrised paddle block for the VGA ping-pong game. It combines the paddle control FSM and datapath into one unit and supports a rectangular paddle of any size, configurable movement bounds, step size and colour. Each `go` request runs a complete erase → move → draw → done sequence, streaming one pixel per cycle to the shared VGA plot arbiter. The current paddle position is exported for ball-collision logic.

## Interface
- `PAD_W`, 16, paddle width in pixels (1..32)
- `PAD_H`, 2, paddle height in pixels (1..8)
- `X_MIN`, 51, leftmost column the paddle may occupy
- `X_MAX`, 126, rightmost column the paddle may occupy; requires X_MAX−X_MIN+1 ≥ PAD_W
- `X_RESET`, 75, paddle left-edge column after reset; must lie in [X_MIN, X_MAX−PAD_W+1]
- `Y_POS`, 108, top row of the paddle; requires Y_POS+PAD_H ≤ 120
- `STEP`, 2, pixels moved per request (1..15)
- `COLOR`, 3'b010, draw colour; erase colour is always 3'b000
- `clk`  in  1  clock; all state updates on the rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `go`  in  1  start request; sampled only in IDLE
- `left`  in  1  move-left request; latched on an accepted `go`
- `right`  in  1  move-right request; latched on an accepted `go`
- `x_out`  out  8  pixel column
- `y_out`  out  7  pixel row
- `color_out`  out  3  pixel colour
- `plot`  out  1  `x_out`/`y_out`/`color_out` valid this cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a sequence
- `x_pos`  out  8  current paddle left-edge column
- `y_pos`  out  7  constant `Y_POS`

## Operation
- States: IDLE, ERASE, MOVE, DRAW, DONE. All outputs are registered.
- IDLE:
  - `go`=1 moves to ERASE and latches `dir_l`=`left`, `dir_r`=`right`.
  - `go` is ignored in every other state; there is no queuing.
- ERASE: emits N = PAD_W·PAD_H pixels at the pre-move position, one per cycle.
  - Raster order: column offset cx fastest (0..PAD_W−1), then row offset cy (0..PAD_H−1).
  - `x_out` = x_pos+cx, `y_out` = Y_POS+cy, `color_out` = 0, `plot` = 1.
  - After the last pixel, go to MOVE.
- MOVE: one cycle with `plot` = 0. Position update rules:
  - `dir_r` only: x_pos ← min(x_pos+STEP, X_MAX−PAD_W+1). Compute in 9 bits so nothing wraps.
  - `dir_l` only: x_pos ← X_MIN if x_pos < X_MIN+STEP, else x_pos−STEP. Never underflows.
  - Both or neither: x_pos is unchanged. The full erase/draw still runs.
- DRAW: same N-pixel raster as ERASE, at the new x_pos, with `color_out` = COLOR. Then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- Pixel counters: cx and cy are reset to 0 on entry to ERASE and to DRAW.
- Reset (asynchronous, any state, including mid-stream):
  - State goes to IDLE, x_pos = X_RESET, cx = cy = 0, `dir_l` = `dir_r` = 0.
  - Outputs: `plot` = 0, `done` = 0, `busy` = 0, `x_out` = 0, `y_out` = 0, `color_out` = 0.
  - Pixels already emitted are not undone; the top level redraws after reset.

## Timing
- Cycle 0 is the edge on which `go` is accepted in IDLE.
- ERASE pixels occupy cycles 1..N, MOVE is cycle N+1, DRAW pixels occupy cycles N+2..2N+1.
- `done` is high in cycle 2N+2. IDLE is entered at cycle 2N+3, where a new `go` is accepted.
- Total sequence latency: 2N+3 cycles. With default parameters: N = 32, `done` at cycle 66.
- `busy` rises in cycle 1 and falls in cycle 2N+3.
- `x_pos` changes only on the MOVE→DRAW edge; it is stable in every other cycle.
- `left` and `right` are don't-care outside the `go`-accepted cycle.
- No backpressure: the downstream consumer must accept one pixel per cycle while `plot` = 1.

## Test plan
- Reset then idle for 10 cycles → `x_pos` = 75, `y_pos` = 108, `plot` = `done` = `busy` = 0.
- `go`=1, `right`=1 for one cycle from `x_pos` = 75:
  - 32 erase pixels, colour 0: (75,108)..(90,108), then (75,109)..(90,109).
  - 32 draw pixels, colour 010, at x = 77..92.
  - `done` high only in cycle 66; `x_pos` = 77.
- Right clamp: from `x_pos` = 110, request right → 111; request right again → 111, with a full erase/draw pass.
- Left clamp and both-pressed:
  - From `x_pos` = 52, request left → 51.
  - `left`=`right`=1 → stays 51; 64 plot cycles still occur.
- Latching and `go` filtering:
  - Toggle `right` and pulse `go` during ERASE → no second sequence; direction unchanged.
  - `done` appears exactly once per accepted `go`.
- Reset mid-operation: assert `resetn`=0 at cycle 40 (inside DRAW) → `plot` = 0 immediately, `x_pos` = 75, `busy` = 0. After release, a new `go` starts cleanly.

Source files
------------

// File: rtl/paddle_engine.sv
// Paddle engine: erase -> move -> draw -> done sequencer for one rectangular
// paddle, streaming one pixel per cycle to the VGA plot arbiter and exporting
// the paddle position for ball-collision logic.
module paddle_engine #(
  parameter int         PAD_W   = 16,
  parameter int         PAD_H   = 2,
  parameter int         X_MIN   = 51,
  parameter int         X_MAX   = 126,
  parameter int         X_RESET = 75,
  parameter int         Y_POS   = 108,
  parameter int         STEP    = 2,
  parameter logic [2:0] COLOR   = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       left,
  input  logic       right,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos
);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;

  localparam logic [4:0] CX_LAST = 5'(PAD_W - 1);
  localparam logic [2:0] CY_LAST = 3'(PAD_H - 1);
  localparam logic [7:0] X_HI    = 8'(X_MAX - PAD_W + 1);
  localparam logic [6:0] Y0      = 7'(Y_POS);

  state_t     state, state_n;
  logic [4:0] cx, cx_n, cx_adv;
  logic [2:0] cy, cy_n, cy_adv;
  logic       dir_l, dir_l_n, dir_r, dir_r_n;
  logic [7:0] x_pos_n, x_out_n, moved;
  logic [6:0] y_out_n;
  logic [2:0] color_n;
  logic       plot_n, busy_n, done_n, last_px;
  logic [8:0] right_sum;

  assign y_pos = Y0;

  // Raster bookkeeping: is the pixel on screen the last one, and which pixel follows it.
  always_comb begin
    last_px = (cx == CX_LAST) && (cy == CY_LAST);
    cx_adv  = cx + 5'd1;
    cy_adv  = cy;
    if (cx == CX_LAST) begin
      cx_adv = 5'd0;
      cy_adv = cy + 3'd1;
    end
  end

  // Clamped position update; the right move is summed in 9 bits so it cannot wrap.
  always_comb begin
    right_sum = {1'b0, x_pos} + 9'(STEP);
    moved     = x_pos;
    if (dir_r && !dir_l) begin
      moved = (right_sum > {1'b0, X_HI}) ? X_HI : right_sum[7:0];
    end else if (dir_l && !dir_r) begin
      moved = ({1'b0, x_pos} < 9'(X_MIN + STEP)) ? 8'(X_MIN) : x_pos - 8'(STEP);
    end
  end

  // Next-state and next-output logic; every output is registered one step ahead.
  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    dir_l_n = dir_l;
    dir_r_n = dir_r;
    x_pos_n = x_pos;
    x_out_n = x_out;
    y_out_n = y_out;
    color_n = color_out;
    plot_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_n = S_ERASE;
          dir_l_n = left;
          dir_r_n = right;
          cx_n    = 5'd0;
          cy_n    = 3'd0;
          plot_n  = 1'b1;
          x_out_n = x_pos;
          y_out_n = Y0;
          color_n = 3'b000;
        end
      end
      S_ERASE: begin
        if (last_px) begin
          state_n = S_MOVE;
          cx_n    = 5'd0;
          cy_n    = 3'd0;
        end else begin
          cx_n    = cx_adv;
          cy_n    = cy_adv;
          plot_n  = 1'b1;
          x_out_n = x_pos + {3'b000, cx_adv};
          y_out_n = Y0 + {4'b0000, cy_adv};
        end
      end
      S_MOVE: begin
        state_n = S_DRAW;
        x_pos_n = moved;
        cx_n    = 5'd0;
        cy_n    = 3'd0;
        plot_n  = 1'b1;
        x_out_n = moved;
        y_out_n = Y0;
        color_n = COLOR;
      end
      S_DRAW: begin
        if (last_px) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          cx_n    = 5'd0;
          cy_n    = 3'd0;
        end else begin
          cx_n    = cx_adv;
          cy_n    = cy_adv;
          plot_n  = 1'b1;
          x_out_n = x_pos + {3'b000, cx_adv};
          y_out_n = Y0 + {4'b0000, cy_adv};
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State, position and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cx        <= 5'd0;
      cy        <= 3'd0;
      dir_l     <= 1'b0;
      dir_r     <= 1'b0;
      x_pos     <= 8'(X_RESET);
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      color_out <= 3'b000;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cx        <= cx_n;
      cy        <= cy_n;
      dir_l     <= dir_l_n;
      dir_r     <= dir_r_n;
      x_pos     <= x_pos_n;
      x_out     <= x_out_n;
      y_out     <= y_out_n;
      color_out <= color_n;
      plot      <= plot_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_paddle_engine.sv
// Self-checking bench for paddle_engine: table of move requests with fixed
// expected positions, hand-written clamp / filtering / reset sequences, and
// randomized requests checked cycle by cycle against a position/raster model.
module tb_paddle_engine;

  localparam int W    = 16;
  localparam int H    = 2;
  localparam int N    = W * H;
  localparam int XMIN = 51;
  localparam int XMAX = 126;
  localparam int XRST = 75;
  localparam int YP   = 108;
  localparam int STEP = 2;
  localparam int COL  = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;
  logic       plot, busy, done;
  logic [7:0] x_pos;
  logic [6:0] y_pos;

  paddle_engine #(
    .PAD_W(W), .PAD_H(H), .X_MIN(XMIN), .X_MAX(XMAX), .X_RESET(XRST),
    .Y_POS(YP), .STEP(STEP), .COLOR(3'b010)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .left(left), .right(right),
    .x_out(x_out), .y_out(y_out), .color_out(color_out), .plot(plot),
    .busy(busy), .done(done), .x_pos(x_pos), .y_pos(y_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int mpos;

  typedef struct {
    bit l;
    bit r;
    int exp_x;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  // Position after a request, straight from the movement rules.
  function automatic int model_move(input int p, input bit l, input bit r);
    if (r && !l) return (p + STEP > XMAX - W + 1) ? XMAX - W + 1 : p + STEP;
    if (l && !r) return (p - STEP < XMIN) ? XMIN : p - STEP;
    return p;
  endfunction

  // Expected outputs k cycles after the accepting edge.
  task automatic check_cycle(input int k, input int oldp, input int newp);
    bit pe, be, de;
    int idx, base, col;
    pe = (k >= 1 && k <= N) || (k >= N + 2 && k <= 2 * N + 1);
    be = (k <= 2 * N + 2);
    de = (k == 2 * N + 2);
    chk("plot", k, plot, pe);
    chk("busy", k, busy, be);
    chk("done", k, done, de);
    chk("x_pos", k, x_pos, (k <= N + 1) ? oldp : newp);
    if (pe) begin
      idx  = (k <= N) ? k - 1 : k - N - 2;
      base = (k <= N) ? oldp : newp;
      col  = (k <= N) ? 0 : COL;
      chk("x_out", k, x_out, base + idx % W);
      chk("y_out", k, y_out, YP + idx / W);
      chk("color", k, color_out, col);
    end
  endtask

  // One full request; called just after a falling edge, returns on one.
  task automatic run_seq(input bit l, input bit r, input bit noise);
    int oldp, newp;
    oldp = mpos;
    newp = model_move(mpos, l, r);
    go = 1'b1;
    left = l;
    right = r;
    @(posedge clk);
    for (int k = 1; k <= 2 * N + 3; k++) begin
      @(negedge clk);
      check_cycle(k, oldp, newp);
      left  = 1'($urandom_range(0, 1));
      right = noise ? ~right : 1'($urandom_range(0, 1));
      go    = (noise && k < N) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    go = 1'b0;
    mpos = newp;
  endtask

  initial begin
    int oldp, newp;
    vecs[0] = '{l: 1'b0, r: 1'b1, exp_x: 77};
    vecs[1] = '{l: 1'b0, r: 1'b1, exp_x: 79};
    vecs[2] = '{l: 1'b1, r: 1'b0, exp_x: 77};
    vecs[3] = '{l: 1'b1, r: 1'b1, exp_x: 77};
    vecs[4] = '{l: 1'b0, r: 1'b0, exp_x: 77};
    vecs[5] = '{l: 1'b1, r: 1'b0, exp_x: 75};

    // Reset and idle
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mpos = XRST;
    repeat (10) @(negedge clk);
    chk("rst_x_pos", 0, x_pos, 75);
    chk("rst_y_pos", 0, y_pos, 108);
    chk("rst_plot", 0, plot, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_x_out", 0, x_out, 0);

    // Table of requests with fixed expected positions
    for (int i = 0; i < 6; i++) begin
      run_seq(vecs[i].l, vecs[i].r, 1'b0);
      chk("tbl_x_pos", i, x_pos, vecs[i].exp_x);
    end

    // Right clamp
    for (int i = 0; i < 40 && mpos != XMAX - W + 1; i++) run_seq(1'b0, 1'b1, 1'b0);
    chk("clamp_r", 0, x_pos, 111);
    run_seq(1'b0, 1'b1, 1'b0);
    chk("clamp_r_again", 0, x_pos, 111);
    run_seq(1'b1, 1'b0, 1'b0);
    chk("left_from_r", 0, x_pos, 109);

    // Left clamp and both pressed
    for (int i = 0; i < 40 && mpos != XMIN; i++) run_seq(1'b1, 1'b0, 1'b0);
    chk("clamp_l", 0, x_pos, 51);
    run_seq(1'b1, 1'b1, 1'b0);
    chk("both_l", 0, x_pos, 51);
    run_seq(1'b1, 1'b0, 1'b0);
    chk("clamp_l_again", 0, x_pos, 51);

    // go / direction toggling during ERASE must be ignored
    run_seq(1'b0, 1'b1, 1'b1);
    chk("noise_x_pos", 0, x_pos, 53);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noise_idle_busy", i, busy, 0);
      chk("noise_idle_done", i, done, 0);
    end

    // Reset in the middle of DRAW
    oldp = mpos;
    newp = model_move(mpos, 1'b0, 1'b1);
    go = 1'b1;
    left = 1'b0;
    right = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      go = 1'b0;
      check_cycle(k, oldp, newp);
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 40, plot, 0);
    chk("mid_rst_busy", 40, busy, 0);
    chk("mid_rst_done", 40, done, 0);
    chk("mid_rst_x_pos", 40, x_pos, 75);
    chk("mid_rst_x_out", 40, x_out, 0);
    mpos = XRST;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 0, busy, 0);
    run_seq(1'b0, 1'b1, 1'b0);
    chk("post_rst_x_pos", 0, x_pos, 77);

    // Randomized requests with idle gaps
    for (int s = 0; s < 40; s++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        go = 1'b0;
        @(negedge clk);
        chk("gap_busy", g, busy, 0);
        chk("gap_plot", g, plot, 0);
        chk("gap_x_pos", g, x_pos, mpos);
      end
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
